// File: rtl/alu_ctrl_pkg.sv
// Shared ALU control definitions for the EX stage.
// Holds the 4-bit ALU control codes produced by the ALU control decoder
// and the state encoding for the multi-cycle multiply/divide unit.
package alu_ctrl_pkg;

  localparam logic [3:0] ALU_AND  = 4'b0000;
  localparam logic [3:0] ALU_OR   = 4'b0001;
  localparam logic [3:0] ALU_ADD  = 4'b0010;
  localparam logic [3:0] ALU_MULT = 4'b0101;
  localparam logic [3:0] ALU_SUB  = 4'b0110;
  localparam logic [3:0] ALU_SLT  = 4'b0111;
  localparam logic [3:0] ALU_DIV  = 4'b1011;
  localparam logic [3:0] ALU_NOR  = 4'b1100;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    FIX
  } mdu_state_e;

endpackage

// File: rtl/mdu_iter_step.sv
// Single iteration of the multiply/divide datapath (purely combinational).
// Ports:
//   is_div   : 1 = restoring-divide step, 0 = shift-add multiply step
//   acc      : current accumulator {upper, lower}
//              mult: {partial product, remaining multiplier bits}
//              div : {partial remainder, dividend bits / quotient bits}
//   operand  : |A| (multiplicand) for mult, |B| (divisor) for div
//   acc_next : accumulator after one iteration
module mdu_iter_step #(
  parameter int unsigned WIDTH = 32
) (
  input  logic                 is_div,
  input  logic [2*WIDTH-1:0]   acc,
  input  logic [WIDTH-1:0]     operand,
  output logic [2*WIDTH-1:0]   acc_next
);

  logic [WIDTH:0]   sum;
  logic [WIDTH:0]   shifted;
  logic [WIDTH:0]   trial;
  logic [WIDTH-1:0] rem;

  always_comb begin
    // mult: add multiplicand into the upper half when the multiplier LSB is
    // set, then shift the whole accumulator right (carry enters at the top).
    sum = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, operand} : '0);

    // div: shift the next dividend bit into the remainder, trial-subtract,
    // restore on borrow; the quotient bit enters at the LSB.
    shifted = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
    trial   = shifted - {1'b0, operand};
    rem     = trial[WIDTH] ? shifted[WIDTH-1:0] : trial[WIDTH-1:0];

    if (is_div)
      acc_next = {rem, acc[WIDTH-2:0], ~trial[WIDTH]};
    else
      acc_next = {sum, acc[WIDTH-1:1]};
  end

endmodule

// File: rtl/mult_div_unit.sv
// Multi-cycle signed multiply/divide unit writing HI/LO.
// Ports:
//   Clk, Reset    : rising-edge clock, asynchronous active-high reset
//   Start         : request strobe, acted on only in IDLE with mult/div code
//   ALU_Control   : 4-bit ALU code; ALU_MULT and ALU_DIV are executed
//   A, B          : two's complement operands (stable at the accepting edge)
//   Busy          : high while an operation is in RUN/FIX
//   Done          : one-cycle pulse when HI/LO are written
//   DivByZero     : last divide had B == 0, cleared by the next accepted Start
//   HI, LO        : product high/low, or remainder/quotient
module mult_div_unit
  import alu_ctrl_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             Start,
  input  logic [3:0]       ALU_Control,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             Busy,
  output logic             Done,
  output logic             DivByZero,
  output logic [WIDTH-1:0] HI,
  output logic [WIDTH-1:0] LO
);

  localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  mdu_state_e         state, state_next;
  logic               op_div, sign_a, sign_b;
  logic [WIDTH-1:0]   mag_a, mag_b;
  logic [WIDTH-1:0]   a_mag_in, b_mag_in;
  logic [2*WIDTH-1:0] acc, acc_next, prod;
  logic [CW-1:0]      cnt;
  logic               is_code, load, step, finish;
  logic [WIDTH-1:0]   hi_res, lo_res;

  assign is_code  = (ALU_Control == ALU_MULT) || (ALU_Control == ALU_DIV);
  assign a_mag_in = A[WIDTH-1] ? -A : A;
  assign b_mag_in = B[WIDTH-1] ? -B : B;

  mdu_iter_step #(
    .WIDTH (WIDTH)
  ) u_step (
    .is_div   (op_div),
    .acc      (acc),
    .operand  (op_div ? mag_b : mag_a),
    .acc_next (acc_next)
  );

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    load       = 1'b0;
    step       = 1'b0;
    finish     = 1'b0;
    case (state)
      IDLE: if (Start && is_code) begin
        load       = 1'b1;
        state_next = RUN;
      end
      RUN: begin
        step = 1'b1;
        if (cnt == CW'(WIDTH-1)) state_next = FIX;
      end
      FIX: begin
        finish     = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Sign fix. For a zero divisor the restoring loop leaves remainder = |A|
  // and quotient = all ones, so giving the remainder A's sign reproduces A
  // in HI; only the quotient negation must be suppressed.
  always_comb begin
    prod   = (sign_a ^ sign_b) ? -acc : acc;
    hi_res = prod[2*WIDTH-1:WIDTH];
    lo_res = prod[WIDTH-1:0];
    if (op_div) begin
      hi_res = sign_a ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];
      lo_res = ((sign_a ^ sign_b) && (mag_b != '0)) ? -acc[WIDTH-1:0]
                                                     : acc[WIDTH-1:0];
    end
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      op_div    <= 1'b0;
      sign_a    <= 1'b0;
      sign_b    <= 1'b0;
      mag_a     <= '0;
      mag_b     <= '0;
      acc       <= '0;
      cnt       <= '0;
      HI        <= '0;
      LO        <= '0;
      Busy      <= 1'b0;
      Done      <= 1'b0;
      DivByZero <= 1'b0;
    end else begin
      Done <= 1'b0;
      if (load) begin
        op_div    <= (ALU_Control == ALU_DIV);
        sign_a    <= A[WIDTH-1];
        sign_b    <= B[WIDTH-1];
        mag_a     <= a_mag_in;
        mag_b     <= b_mag_in;
        acc       <= {{WIDTH{1'b0}}, (ALU_Control == ALU_DIV) ? a_mag_in : b_mag_in};
        cnt       <= '0;
        DivByZero <= 1'b0;
        Busy      <= 1'b1;
      end
      if (step) begin
        acc <= acc_next;
        cnt <= cnt + 1'b1;
      end
      if (finish) begin
        HI        <= hi_res;
        LO        <= lo_res;
        DivByZero <= op_div && (mag_b == '0);
        Busy      <= 1'b0;
        Done      <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_mult_div_unit.sv
// Directed bench for mult_div_unit (WIDTH = 32), expected values hand-computed.
module tb_mult_div_unit;

  logic        Clk = 1'b0;
  logic        Reset;
  logic        Start;
  logic [3:0]  ALU_Control;
  logic [31:0] A, B;
  logic        Busy, Done, DivByZero;
  logic [31:0] HI, LO;

  int compared   = 0;
  int mismatched = 0;
  int cycles;
  int busy_cnt;
  int done_seen;

  mult_div_unit #(.WIDTH(32)) dut (
    .Clk         (Clk),
    .Reset       (Reset),
    .Start       (Start),
    .ALU_Control (ALU_Control),
    .A           (A),
    .B           (B),
    .Busy        (Busy),
    .Done        (Done),
    .DivByZero   (DivByZero),
    .HI          (HI),
    .LO          (LO)
  );

  always #5 Clk = ~Clk;

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Present a request and pass the accepting edge.
  task automatic start_op(input logic [3:0] code, input logic [31:0] a, input logic [31:0] b);
    ALU_Control = code;
    A           = a;
    B           = b;
    Start       = 1'b1;
    tick();
    Start       = 1'b0;
    A           = 32'hDEAD_BEEF;
    B           = 32'h1234_5678;
  endtask

  // Wait (bounded) for Done; counts cycles and Busy-high samples on the way.
  task automatic wait_done(output int n, output int busy_n);
    n      = 0;
    busy_n = Busy ? 1 : 0;
    while (!Done && n < 60) begin
      tick();
      n++;
      if (Busy) busy_n++;
    end
    if (!Done) check("done_timeout", 64'(n), 64'd33);
  endtask

  initial begin
    Reset       = 1'b1;
    Start       = 1'b0;
    ALU_Control = 4'b0000;
    A           = '0;
    B           = '0;
    repeat (3) tick();
    check("rst_busy", 64'(Busy), 64'd0);
    check("rst_done", 64'(Done), 64'd0);
    check("rst_dbz",  64'(DivByZero), 64'd0);
    check("rst_hi",   64'(HI), 64'd0);
    check("rst_lo",   64'(LO), 64'd0);
    Reset = 1'b0;
    tick();

    // mult 7 * -3 = -21
    start_op(4'b0101, 32'd7, 32'hFFFF_FFFD);
    wait_done(cycles, busy_cnt);
    check("mul1_latency", 64'(cycles), 64'd33);
    check("mul1_busy_cycles", 64'(busy_cnt), 64'd33);
    check("mul1_busy_in_done", 64'(Busy), 64'd0);
    check("mul1_hi", 64'(HI), 64'h0000_0000_FFFF_FFFF);
    check("mul1_lo", 64'(LO), 64'h0000_0000_FFFF_FFEB);
    tick();
    check("mul1_done_pulse", 64'(Done), 64'd0);

    // mult 0x80000000 * 0x80000000 = 2^62
    start_op(4'b0101, 32'h8000_0000, 32'h8000_0000);
    wait_done(cycles, busy_cnt);
    check("mul2_hi", 64'(HI), 64'h0000_0000_4000_0000);
    check("mul2_lo", 64'(LO), 64'd0);
    tick();

    // div -7 / 2 = -3 rem -1, then back-to-back 100 / 7 from the Done cycle
    start_op(4'b1011, 32'hFFFF_FFF9, 32'd2);
    wait_done(cycles, busy_cnt);
    check("div1_latency", 64'(cycles), 64'd33);
    check("div1_lo", 64'(LO), 64'h0000_0000_FFFF_FFFD);
    check("div1_hi", 64'(HI), 64'h0000_0000_FFFF_FFFF);
    start_op(4'b1011, 32'd100, 32'd7);
    check("b2b_accept_busy", 64'(Busy), 64'd1);
    wait_done(cycles, busy_cnt);
    check("div2_latency", 64'(cycles), 64'd33);
    check("div2_lo", 64'(LO), 64'd14);
    check("div2_hi", 64'(HI), 64'd2);
    check("div2_dbz", 64'(DivByZero), 64'd0);
    tick();

    // most-negative / -1 wraps, no flag
    start_op(4'b1011, 32'h8000_0000, 32'hFFFF_FFFF);
    wait_done(cycles, busy_cnt);
    check("divwrap_lo", 64'(LO), 64'h0000_0000_8000_0000);
    check("divwrap_hi", 64'(HI), 64'd0);
    check("divwrap_dbz", 64'(DivByZero), 64'd0);
    tick();

    // div 5 / 0
    start_op(4'b1011, 32'd5, 32'd0);
    wait_done(cycles, busy_cnt);
    check("div0_lo", 64'(LO), 64'h0000_0000_FFFF_FFFF);
    check("div0_hi", 64'(HI), 64'd5);
    check("div0_flag", 64'(DivByZero), 64'd1);
    tick();
    check("div0_flag_held", 64'(DivByZero), 64'd1);

    // div -9 / 0: HI returns A unchanged, no quotient sign fix
    start_op(4'b1011, 32'hFFFF_FFF7, 32'd0);
    wait_done(cycles, busy_cnt);
    check("div0n_lo", 64'(LO), 64'h0000_0000_FFFF_FFFF);
    check("div0n_hi", 64'(HI), 64'h0000_0000_FFFF_FFF7);
    tick();

    // Start with a non-mult/div code is ignored
    start_op(4'b0010, 32'd1, 32'd1);
    check("ign_busy", 64'(Busy), 64'd0);
    tick();
    check("ign_done", 64'(Done), 64'd0);
    check("ign_dbz", 64'(DivByZero), 64'd1);
    check("ign_hi", 64'(HI), 64'h0000_0000_FFFF_FFF7);
    check("ign_lo", 64'(LO), 64'h0000_0000_FFFF_FFFF);

    // mult 3 * 4 with Start pulses while busy; accepted Start clears DivByZero
    start_op(4'b0101, 32'd3, 32'd4);
    check("clr_dbz", 64'(DivByZero), 64'd0);
    repeat (5) tick();
    start_op(4'b1011, 32'd50, 32'd5);
    start_op(4'b0101, 32'd9, 32'd9);
    wait_done(cycles, busy_cnt);
    check("busy_start_latency", 64'(cycles), 64'd26);
    check("mul3_hi", 64'(HI), 64'd0);
    check("mul3_lo", 64'(LO), 64'd12);
    done_seen = 0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (Done || Busy) done_seen++;
    end
    check("no_extra_done", 64'(done_seen), 64'd0);
    check("mul3_lo_hold", 64'(LO), 64'd12);

    // asynchronous reset 10 cycles into a mult
    start_op(4'b0101, 32'd7, 32'hFFFF_FFFD);
    repeat (9) tick();
    #2;
    Reset = 1'b1;
    #1;
    check("arst_busy", 64'(Busy), 64'd0);
    check("arst_hi", 64'(HI), 64'd0);
    check("arst_lo", 64'(LO), 64'd0);
    tick();
    Reset = 1'b0;
    done_seen = 0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (Done) done_seen++;
    end
    check("arst_no_done", 64'(done_seen), 64'd0);
    check("arst_lo_hold", 64'(LO), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
